// File: rtl/cip_mubi_stim_gen.sv
// Mubi stimulus generator: walks each channel through TRUE, FALSE and
// every single-bit flip of TRUE, holding each value HoldCycles cycles.
module cip_mubi_stim_gen #(
  parameter int unsigned      NumMubis   = 1,
  parameter int unsigned      Width      = 4,
  parameter logic [Width-1:0] TrueVal    = 4'h6,
  parameter logic [Width-1:0] FalseVal   = 4'h9,
  parameter int unsigned      HoldCycles = 2,
  localparam int unsigned     IdxW = $clog2(NumMubis > 1 ? NumMubis : 2)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             pause_i,
  input  logic                             abort_i,
  output logic [NumMubis-1:0][Width-1:0]   mubis_o,
  output logic [IdxW-1:0]                  cur_idx_o,
  output logic                             busy_o,
  output logic                             done_o
);

  if (FalseVal != ~TrueVal) begin : gen_bad_false
    $error("FalseVal must be the complement of TrueVal");
  end
  if (NumMubis < 1 || Width < 2 || HoldCycles < 1) begin : gen_bad_param
    $error("NumMubis>=1, Width>=2 and HoldCycles>=1 required");
  end

  localparam int unsigned HoldW = $clog2(HoldCycles > 1 ? HoldCycles : 2);
  localparam int unsigned StepW = $clog2(Width);

  localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles - 1);
  localparam logic [StepW-1:0] StepMax = StepW'(Width - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NumMubis - 1);

  typedef logic [NumMubis-1:0][Width-1:0] arr_t;

  localparam arr_t AllFalse = {NumMubis{FalseVal}};

  typedef enum logic [1:0] {
    IDLE,
    DRV_TRUE,
    DRV_FALSE,
    DRV_INV
  } state_e;

  state_e           state;
  logic [HoldW-1:0] hold;
  logic [StepW-1:0] step;

  function automatic arr_t drive(
    input logic [IdxW-1:0]  idx,
    input logic [Width-1:0] val
  );
    arr_t a;
    for (int i = 0; i < NumMubis; i++) begin
      a[i] = (IdxW'(i) == idx) ? val : FalseVal;
    end
    return a;
  endfunction

  function automatic logic [Width-1:0] inv_val(
    input logic [StepW-1:0] k
  );
    return TrueVal ^ (Width'(1) << k);
  endfunction

  // Sweep FSM: hold counter, step walk and registered lane outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      hold      <= '0;
      step      <= '0;
      mubis_o   <= AllFalse;
      cur_idx_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        mubis_o <= AllFalse;
        if (start_i) begin
          state     <= DRV_TRUE;
          hold      <= '0;
          step      <= '0;
          cur_idx_o <= '0;
          busy_o    <= 1'b1;
          mubis_o   <= drive('0, TrueVal);
        end
      end else if (abort_i) begin
        state     <= IDLE;
        hold      <= '0;
        step      <= '0;
        mubis_o   <= AllFalse;
        cur_idx_o <= '0;
        busy_o    <= 1'b0;
      end else if (!pause_i) begin
        if (hold != HoldMax) begin
          hold <= hold + HoldW'(1);
        end else begin
          hold <= '0;
          unique case (state)
            DRV_TRUE: begin
              state   <= DRV_FALSE;
              mubis_o <= AllFalse;
            end
            DRV_FALSE: begin
              state   <= DRV_INV;
              step    <= '0;
              mubis_o <= drive(cur_idx_o, inv_val('0));
            end
            default: begin
              unique case (1'b1)
                (step != StepMax): begin
                  step    <= step + StepW'(1);
                  mubis_o <= drive(cur_idx_o,
                                   inv_val(step + StepW'(1)));
                end
                (step == StepMax && cur_idx_o != IdxMax): begin
                  step      <= '0;
                  state     <= DRV_TRUE;
                  cur_idx_o <= cur_idx_o + IdxW'(1);
                  mubis_o   <= drive(cur_idx_o + IdxW'(1), TrueVal);
                end
                default: begin
                  step      <= '0;
                  state     <= IDLE;
                  cur_idx_o <= '0;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  mubis_o   <= AllFalse;
                end
              endcase
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cip_mubi_stim_gen.sv
// Bench for cip_mubi_stim_gen: directed scenarios plus random
// stimulus against a sweep-position reference model.
module tb_cip_mubi_stim_gen;

  localparam int N     = 2;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int Total = N * (W + 2) * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, pause, abort;
  logic [N-1:0][W-1:0] mubis;
  logic [0:0] idx;
  logic busy, done;

  logic rst_b, start_b;
  logic [0:0][1:0] mubis_b;
  logic [0:0] idx_b;
  logic busy_b, done_b;

  int compared   = 0;
  int mismatched = 0;

  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_pos  = 0;

  cip_mubi_stim_gen #(
    .NumMubis(N), .Width(W), .TrueVal(4'h6),
    .FalseVal(4'h9), .HoldCycles(H)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .pause_i(pause), .abort_i(abort), .mubis_o(mubis),
    .cur_idx_o(idx), .busy_o(busy), .done_o(done)
  );

  cip_mubi_stim_gen #(
    .NumMubis(1), .Width(2), .TrueVal(2'b01),
    .FalseVal(2'b10), .HoldCycles(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b),
    .pause_i(1'b0), .abort_i(1'b0), .mubis_o(mubis_b),
    .cur_idx_o(idx_b), .busy_o(busy_b), .done_o(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][W-1:0] exp_lanes();
    logic [N-1:0][W-1:0] e;
    int v, ch, s;
    for (int i = 0; i < N; i++) e[i] = 4'h9;
    if (m_busy) begin
      v  = m_pos / H;
      ch = v / (W + 2);
      s  = v % (W + 2);
      if (s == 0)      e[ch] = 4'h6;
      else if (s == 1) e[ch] = 4'h9;
      else             e[ch] = 4'h6 ^ (4'h1 << (s - 2));
    end
    return e;
  endfunction

  task automatic cyc(input bit st, input bit pa, input bit ab,
                     input bit rs);
    start = st;
    pause = pa;
    abort = ab;
    rst   = rs;
    @(posedge clk);
    if (rs) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_done = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (st) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end else begin
      m_done = 1'b0;
      if (ab) m_busy = 1'b0;
      else if (!pa) begin
        if (m_pos == Total - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else m_pos++;
      end
    end
    #1;
    chk("model_mubis", 32'(mubis), 32'(exp_lanes()));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_idx", 32'(idx),
        m_busy ? 32'((m_pos / H) / (W + 2)) : 32'd0);
  endtask

  initial begin
    logic [3:0] tbl [12];
    logic [1:0] tbl_b [4];
    tbl   = '{4'h6, 4'h6, 4'h9, 4'h9, 4'h7, 4'h7,
              4'h4, 4'h4, 4'h2, 4'h2, 4'hE, 4'hE};
    tbl_b = '{2'd1, 2'd2, 2'd0, 2'd3};
    rst_b   = 1'b1;
    start_b = 1'b0;

    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 1);
    rst_b = 1'b0;
    chk("reset_mubis", 32'(mubis), 32'h99);
    chk("reset_idx", 32'(idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_b_mubis", 32'(mubis_b), 32'h2);

    // full sweep
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      chk("sweep_lane0", 32'(mubis[0]),
          c <= 12 ? 32'(tbl[c-1]) : 32'h9);
      chk("sweep_lane1", 32'(mubis[1]),
          c > 12 ? 32'(tbl[c-13]) : 32'h9);
      chk("sweep_busy", 32'(busy), 32'd1);
      cyc(0, 0, 0, 0);
    end
    chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_end_busy", 32'(busy), 32'd0);
    chk("sweep_end_idx", 32'(idx), 32'd0);
    cyc(0, 0, 0, 0);

    // pause on cycles 4-6
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 28; c++) begin
      if (c == 7)  chk("pause_hold", 32'(mubis[0]), 32'h9);
      if (c == 8)  chk("pause_inv", 32'(mubis[0]), 32'h7);
      if (c == 9)  chk("pause_inv2", 32'(mubis[0]), 32'h7);
      if (c == 27) chk("pause_no_done", 32'(done), 32'd0);
      if (c == 28) chk("pause_done", 32'(done), 32'd1);
      if (c < 28) cyc(0, c >= 4 && c <= 6, 0, 0);
    end
    cyc(0, 0, 0, 0);

    // abort at 14, restart at 16
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 17; c++) begin
      if (c == 15) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mubis", 32'(mubis), 32'h99);
      end
      if (c == 17) chk("abort_restart", 32'(mubis[0]), 32'h6);
      if (c < 17) cyc(c == 16, c == 14, c == 14, 0);
    end
    cyc(0, 0, 1, 0);

    // reset mid-sweep with start held through it
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      if (c == 11 || c == 12) begin
        chk("rst_mubis", 32'(mubis), 32'h99);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
      end
      if (c == 13) chk("rst_restart", 32'(mubis[0]), 32'h6);
      if (c < 13) cyc(c >= 10 && c <= 12, 0, 0, c >= 10 && c <= 11);
    end
    cyc(0, 0, 1, 0);

    // ignored starts and back-to-back sweep
    cyc(1, 0, 0, 0);
    for (int c = 1; c <= 26; c++) begin
      if (c == 25) chk("b2b_done", 32'(done), 32'd1);
      if (c == 26) begin
        chk("b2b_lane0", 32'(mubis[0]), 32'h6);
        chk("b2b_busy", 32'(busy), 32'd1);
      end
      if (c < 26) cyc(c == 5 || c == 20 || c == 25, 0, 0, 0);
    end
    cyc(0, 0, 1, 0);

    // narrow configuration
    start_b = 1'b1;
    cyc(0, 0, 0, 0);
    start_b = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        chk("narrow_val", 32'(mubis_b), 32'(tbl_b[c-1]));
        chk("narrow_busy", 32'(busy_b), 32'd1);
      end else begin
        chk("narrow_done", 32'(done_b), 32'd1);
        chk("narrow_idle", 32'(mubis_b), 32'h2);
      end
      if (c < 5) cyc(0, 0, 0, 0);
    end

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cip_mubi_stim_gen.md
Name: cip_mubi_stim_gen

Overview:
- Synthesizable stimulus generator that drives an array of multi-bit-bool (mubi) signals into a DUT input under test.
- It is the driving end of the mubi coverage wrappers that sample such arrays. The coverage side observes TRUE, FALSE and invalid encodings; this block produces them.
- Channels are walked one at a time. Each channel steps through TRUE, FALSE, then every single-bit-flip of TRUE (all invalid). Each value is held for a programmable number of cycles.
- Instantiated in DV harnesses and FPGA self-test tops.

Parameters:
- NumMubis, 1, number of mubi channels driven (>=1).
- Width, 4, bits per mubi value (>=2).
- TrueVal, 4'h6, encoding of TRUE. Width bits.
- FalseVal, 4'h9, encoding of FALSE. Must equal ~TrueVal; elaboration assertion.
- HoldCycles, 2, cycles each value is held (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin a sweep. Sampled only in IDLE.
- pause_i  in  1  freeze the sweep: state, counters and outputs hold.
- abort_i  in  1  terminate the sweep. Return to IDLE without done.
- mubis_o  out  [NumMubis-1:0][Width-1:0]  driven mubi array. Registered.
- cur_idx_o  out  $clog2(max(NumMubis,2))  channel currently under stimulus. Registered.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse on completion of a full sweep.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE.
  - All mubis_o lanes = FalseVal; cur_idx_o=0; busy_o=0; done_o=0.
  - Hold counter and step counter cleared.
  - Reset takes priority over all other inputs, including mid-sweep.
- FSM states: IDLE, DRV_TRUE, DRV_FALSE, DRV_INV.
- IDLE:
  - All lanes drive FalseVal.
  - start_i=1 -> next cycle state=DRV_TRUE, cur_idx_o=0, busy_o=1, lane 0 = TrueVal.
  - Latency start->first value is 1 cycle.
- Lane rules while busy:
  - Only lane cur_idx_o carries the stimulus value.
  - All other lanes drive FalseVal.
- Hold counter:
  - Counts 0..HoldCycles-1 while a value is driven.
  - The value changes on the edge after the count reaches HoldCycles-1.
  - So each value is visible for exactly HoldCycles cycles.
- Step transitions on hold expiry:
  - DRV_TRUE -> DRV_FALSE (lane = FalseVal).
  - DRV_FALSE -> DRV_INV, step k=0 (lane = TrueVal ^ (1<<0)).
  - DRV_INV step k<Width-1 -> k+1 (lane = TrueVal ^ (1<<(k+1))).
  - DRV_INV step k=Width-1:
    - If cur_idx_o<NumMubis-1: cur_idx_o+1, state DRV_TRUE.
    - Else: state IDLE, busy_o=0, all lanes FalseVal, done_o=1 for that single cycle.
- Invalid values: single-bit flips of TRUE are never TRUE. Because FalseVal=~TrueVal and Width>=2, they are never FALSE either, so all Width of them are invalid.
- Sweep length: NumMubis*(Width+2) values. Total busy cycles = NumMubis*(Width+2)*HoldCycles.
- pause_i=1 while busy: hold counter, step, state, cur_idx_o and outputs all frozen. Resumes on the cycle pause_i drops.
- pause_i in IDLE: no effect. start_i with pause_i=1 still starts the sweep.
- abort_i=1 while busy: next cycle state=IDLE, lanes FalseVal, busy_o=0, done_o stays 0.
- abort_i has priority over pause_i.
- start_i while busy is ignored; no restart.
- start_i and abort_i together in IDLE: start wins, because abort has no effect in IDLE.
- start_i in the first cycle after done_o (IDLE): accepted; a new sweep begins on the next cycle.
- cur_idx_o wraps never. It holds NumMubis-1 until IDLE, then resets to 0.

Test Plan:
- Full sweep, NumMubis=2, Width=4, HoldCycles=2, start_i at cycle 0 -> response:
  - Cycles 1-12: lane0 sequence 6,6,9,9,7,7,4,4,2,2,E,E; lane1=9 throughout.
  - Cycles 13-24: same sequence on lane1; lane0=9 throughout.
  - busy_o=1 on cycles 1-24.
  - Cycle 25: done_o=1, busy_o=0, all lanes 9, cur_idx_o=0.
- Pause: same config, pause_i=1 on cycles 4-6 -> response:
  - lane0 holds 9 through cycle 7.
  - Invalid 7 appears at cycles 8-9.
  - done_o shifts to cycle 28.
- Abort: abort_i at cycle 14 -> response:
  - Cycle 15: busy_o=0, all lanes 9, done_o never asserted.
  - A new start_i at cycle 16 restarts from lane0=6 at cycle 17.
- Reset mid-sweep: rst_i=1 at cycle 10 -> response:
  - From cycle 11: all lanes 9, busy_o=0, cur_idx_o=0, done_o=0.
  - start_i held high during reset is not acted upon until reset deasserts.
- Ignored start and back-to-back sweeps: start_i pulsed at cycles 5 and 20 during the sweep -> no effect, done at 25. start_i at cycle 25 -> lane0=6 at cycle 26.
- HoldCycles=1, NumMubis=1, Width=2, TrueVal=2'b01 -> response:
  - Cycles 1-4: values 1,2,0,3.
  - Cycle 5: done_o=1.
